// File: rtl/axi_alu_mem.sv
// -----------------------------------------------------------------------------
// axi_alu_mem
//   AXI-style burst slave in front of a word-addressed memory. Each aligned
//   group of 4 words forms an ALU slot:
//     word0 = op1, word1 = op2, word2 = opcode, word3 = result (read-only).
//   Word3 is recomputed on the edge after any successful write to word0..2.
//
//   Write and read channels run independent FSMs. FIXED/INCR bursts are always
//   supported. WRAP bursts are only supported when the macro
//   AXI_ALU_WRAP_BURST_EN is defined; otherwise they are treated as reserved.
//
// Parameters
//   DATA_WIDTH : beat / memory word width (8, 16 or 32)
//   ADDR_WIDTH : byte address width
//   MEM_WORDS  : memory depth in words (multiple of 4, at least 8)
//
// Ports
//   clk, rstn                                  : clock, synchronous active-low reset
//   awaddr/awlen/awsize/awburst/awvalid/awready : write address channel
//   wdata/wlast/wvalid/wready                  : write data channel
//   bresp/bvalid/bready                        : write response channel
//   araddr/arlen/arsize/arburst/arvalid/arready : read address channel
//   rdata/rresp/rlast/rvalid/rready            : read data channel
//
// Responses: 00 OKAY, 10 SLVERR, 11 DECERR. Their numeric order matches
// severity, so the worst response of a burst is a plain maximum.
// -----------------------------------------------------------------------------
module axi_alu_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  // write address
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [7:0]            awlen,
  input  logic [2:0]            awsize,
  input  logic [1:0]            awburst,
  // write data
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic                  wlast,
  // write response
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  // read address
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [7:0]            arlen,
  input  logic [2:0]            arsize,
  input  logic [1:0]            arburst,
  // read data
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic [1:0]            rresp,
  input  logic                  rready,
  output logic                  rlast
);

  localparam int SHIFT  = $clog2(DATA_WIDTH / 8);
  localparam int MEM_AW = $clog2(MEM_WORDS);

`ifdef AXI_ALU_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] word_addr);
    return word_addr < ADDR_WIDTH'(MEM_WORDS);
  endfunction

  // Burst-wide errors, known as soon as the address phase is seen.
  function automatic logic cfg_error(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size != 3'(SHIFT)) || (burst == 2'b11) ||
           ((burst == BURST_WRAP) && (!WRAP_EN || !wrap_len_ok));
  endfunction

  // Word address of the beat following word_addr. For WRAP, len is a legal
  // power-of-two-minus-one, so it doubles as the in-window offset mask.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] word_addr,
                                                      input logic [1:0]            burst,
                                                      input logic [7:0]            len);
    logic [ADDR_WIDTH-1:0] mask;
    mask = ADDR_WIDTH'(len);
    case (burst)
      BURST_FIXED: return word_addr;
      BURST_WRAP:  return (word_addr & ~mask) | ((word_addr + 1'b1) & mask);
      default:     return word_addr + 1'b1;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] alu(input logic [DATA_WIDTH-1:0] op1,
                                                input logic [DATA_WIDTH-1:0] op2,
                                                input logic [DATA_WIDTH-1:0] opc);
    if (opc > DATA_WIDTH'(7)) return '0;
    case (opc[2:0])
      3'd0:    return op1 + op2;
      3'd1:    return op1 - op2;
      3'd2:    return op1 * op2;
      3'd3:    return op1 << op2[4:0];
      3'd4:    return op1 & op2;
      3'd5:    return op1 | op2;
      3'd6:    return op1 ^ op2;
      default: return op1;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [1:0]            w_burst;
  logic                  w_cfg_err;
  logic [1:0]            w_beat_resp;
  logic                  w_beat;
  logic                  w_commit;
  logic [MEM_AW-1:0]     w_idx;

  assign w_beat   = (w_state == W_DATA) && wvalid && wready;
  assign w_commit = w_beat && (w_beat_resp == RESP_OKAY);
  assign w_idx    = w_addr[MEM_AW-1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_beat_resp = RESP_OKAY;
    if (!in_range(w_addr)) begin
      w_beat_resp = RESP_DECERR;
    end else if (w_cfg_err || (w_addr[1:0] == 2'b11) ||
                 (wlast != (w_cnt == w_len))) begin
      w_beat_resp = RESP_SLVERR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state   <= W_IDLE;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      w_addr    <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_burst   <= BURST_INCR;
      w_cfg_err <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awready && awvalid) begin
            awready   <= 1'b0;
            wready    <= 1'b1;
            bresp     <= RESP_OKAY;
            w_addr    <= awaddr >> SHIFT;
            w_len     <= awlen;
            w_cnt     <= '0;
            w_burst   <= awburst;
            w_cfg_err <= cfg_error(awsize, awburst, awlen);
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (w_beat_resp > bresp) bresp <= w_beat_resp;
            w_addr <= next_addr(w_addr, w_burst, w_len);
            w_cnt  <= w_cnt + 8'd1;
            if (w_cnt == w_len) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              w_state <= W_RESP;
            end
          end
        end
        default: begin
          if (bready) begin
            bvalid  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory update and result recompute
  //   A committed beat marks its slot; on the next edge word3 of that slot is
  //   rebuilt from the freshly written operands. Beats to word3 never commit,
  //   so the two writes cannot collide.
  // ---------------------------------------------------------------------------
  logic              pend_valid;
  logic [MEM_AW-1:0] pend_base;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the memory is cleared by reset because the result slots must
      // read back as zero after reset; this forces a flop-based array.
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
      pend_valid <= 1'b0;
      pend_base  <= '0;
    end else begin
      if (w_commit) mem[w_idx] <= wdata;
      if (pend_valid) begin
        mem[pend_base | MEM_AW'(3)] <= alu(mem[pend_base],
                                           mem[pend_base | MEM_AW'(1)],
                                           mem[pend_base | MEM_AW'(2)]);
      end
      pend_valid <= w_commit;
      pend_base  <= {w_idx[MEM_AW-1:2], 2'b00};
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  //   rf_* describe the beat to load into the output register: the first beat
  //   straight from the AR inputs in R_IDLE, the following beat in R_DATA.
  //   Memory is sampled at the edge, so a same-edge write is not yet visible.
  // ---------------------------------------------------------------------------
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_burst;
  logic                  r_cfg_err;

  logic [ADDR_WIDTH-1:0] rf_addr;
  logic                  rf_cfg_err;
  logic [1:0]            rf_resp;
  logic [DATA_WIDTH-1:0] rf_data;

  always_comb begin
    if (r_state == R_IDLE) begin
      rf_addr    = araddr >> SHIFT;
      rf_cfg_err = cfg_error(arsize, arburst, arlen);
    end else begin
      rf_addr    = next_addr(r_addr, r_burst, r_len);
      rf_cfg_err = r_cfg_err;
    end
    rf_resp = RESP_OKAY;
    if (!in_range(rf_addr)) rf_resp = RESP_DECERR;
    else if (rf_cfg_err)    rf_resp = RESP_SLVERR;
    rf_data = (rf_resp == RESP_OKAY) ? mem[rf_addr[MEM_AW-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= R_IDLE;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= '0;
      rresp     <= RESP_OKAY;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= BURST_INCR;
      r_cfg_err <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arready && arvalid) begin
            arready   <= 1'b0;
            rvalid    <= 1'b1;
            rdata     <= rf_data;
            rresp     <= rf_resp;
            rlast     <= (arlen == 8'd0);
            r_addr    <= rf_addr;
            r_len     <= arlen;
            r_cnt     <= '0;
            r_burst   <= arburst;
            r_cfg_err <= rf_cfg_err;
            r_state   <= R_DATA;
          end
        end
        default: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              r_state <= R_IDLE;
            end else begin
              r_addr <= rf_addr;
              rdata  <= rf_data;
              rresp  <= rf_resp;
              r_cnt  <= r_cnt + 8'd1;
              rlast  <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_alu_mem.sv
// -----------------------------------------------------------------------------
// tb_axi_alu_mem
//   Directed bench for axi_alu_mem with DATA_WIDTH=8 (byte address == word
//   index) and MEM_WORDS=128 so that slot 0x40 is addressable. Inputs are
//   driven and outputs sampled on the falling edge. Expected WRAP behaviour
//   follows AXI_ALU_WRAP_BURST_EN as seen by this compile.
// -----------------------------------------------------------------------------
module tb_axi_alu_mem;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int MW = 128;

  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 1'b0, arvalid = 1'b0;
  logic          awready, arready;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = INCR, arburst = INCR;
  logic [DW-1:0] wdata = '0;
  logic          wvalid = 1'b0, wlast = 1'b0, wready;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid, rlast, rready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] wbuf    [16];
  logic [DW-1:0] rd_data [16];
  logic [1:0]    rd_resp [16];
  logic          rd_last [16];

  always #5 clk = ~clk;

  axi_alu_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW)) dut (
    .clk(clk), .rstn(rstn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rdata(rdata), .rvalid(rvalid), .rresp(rresp), .rready(rready), .rlast(rlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full write burst from wbuf; returns the B response.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size,
                           output logic [1:0] resp);
    int t;
    @(negedge clk);
    awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    check("aw_ready_wait", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wdata = wbuf[i]; wlast = (i == int'(len)); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      check("w_ready_wait", wready, 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    check("b_valid_wait", bvalid, 1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // Full read burst into rd_*; before beat stall_beat, rready is held low for
  // three cycles while rvalid and rdata (expected stall_exp) must hold.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size,
                          input int stall_beat, input logic [DW-1:0] stall_exp);
    int t;
    @(negedge clk);
    araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    check("ar_ready_wait", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    check("r_first_latency", rvalid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (!rvalid && t < 50) begin @(negedge clk); t++; end
      check("r_valid_wait", rvalid, 1);
      if (i == stall_beat) begin
        repeat (3) begin
          @(negedge clk);
          check("stall_rvalid", rvalid, 1);
          check("stall_rdata", rdata, stall_exp);
        end
      end
      rd_data[i] = rdata; rd_resp[i] = rresp; rd_last[i] = rlast;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  task automatic read1(input string tag, input logic [31:0] addr,
                       input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
    axi_read(addr, 8'd0, INCR, 3'd0, -1, '0);
    check({tag, "_data"}, rd_data[0], exp_data);
    check({tag, "_resp"}, rd_resp[0], exp_resp);
    check({tag, "_last"}, rd_last[0], 1);
  endtask

  // Slot table: base, op1, op2, opcode, expected result
  logic [7:0] slot_tbl [6][5] = '{
    '{8'h10, 8'd10, 8'd4,  8'd1, 8'd6},
    '{8'h20, 8'd15, 8'd16, 8'd2, 8'd240},
    '{8'h30, 8'd2,  8'd3,  8'd3, 8'd16},
    '{8'h40, 8'd20, 8'd7,  8'd0, 8'd27},
    '{8'h50, 8'd12, 8'd10, 8'd6, 8'd6},
    '{8'h54, 8'd1,  8'd2,  8'd9, 8'd0}
  };

  initial begin
    logic [1:0]    resp;
    logic [DW-1:0] exp4 [4];
    logic [1:0]    expr;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_wready",  wready,  0);
    check("rst_bvalid",  bvalid,  0);
    check("rst_arready", arready, 0);
    check("rst_rvalid",  rvalid,  0);
    check("rst_rlast",   rlast,   0);
    check("rst_bresp",   bresp,   0);
    check("rst_rresp",   rresp,   0);
    check("rst_rdata",   rdata,   0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_awready", awready, 1);
    check("rel_arready", arready, 1);

    // ---- basic INCR write and 4-beat read ----
    wbuf[0] = 8'd5; wbuf[1] = 8'd3; wbuf[2] = 8'd0;
    axi_write(32'h00, 8'd2, INCR, 3'd0, resp);
    check("add_bresp", resp, OKAY);
    axi_read(32'h00, 8'd3, INCR, 3'd0, -1, '0);
    exp4 = '{8'd5, 8'd3, 8'd0, 8'd8};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("add_rd%0d_data", i), rd_data[i], exp4[i]);
      check($sformatf("add_rd%0d_resp", i), rd_resp[i], OKAY);
      check($sformatf("add_rd%0d_last", i), rd_last[i], (i == 3));
    end

    // ---- ALU slots ----
    for (int s = 0; s < 6; s++) begin
      wbuf[0] = slot_tbl[s][1]; wbuf[1] = slot_tbl[s][2]; wbuf[2] = slot_tbl[s][3];
      axi_write(32'(slot_tbl[s][0]), 8'd2, INCR, 3'd0, resp);
      check($sformatf("slot%0h_bresp", slot_tbl[s][0]), resp, OKAY);
    end
    for (int s = 0; s < 6; s++)
      read1($sformatf("slot%0h_res", slot_tbl[s][0]), 32'(slot_tbl[s][0]) + 32'd3,
            slot_tbl[s][4], OKAY);

    // ---- read backpressure mid-burst ----
    axi_read(32'h10, 8'd3, INCR, 3'd0, 1, 8'd4);
    exp4 = '{8'd10, 8'd4, 8'd1, 8'd6};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_rd%0d_data", i), rd_data[i], exp4[i]);
      check($sformatf("stall_rd%0d_last", i), rd_last[i], (i == 3));
    end

    // ---- write including word3: SLVERR, word3 keeps the computed result ----
    wbuf[0] = 8'd9; wbuf[1] = 8'd5; wbuf[2] = 8'd1; wbuf[3] = 8'd77;
    axi_write(32'h00, 8'd3, INCR, 3'd0, resp);
    check("w3_bresp", resp, SLVERR);
    axi_read(32'h00, 8'd3, INCR, 3'd0, -1, '0);
    exp4 = '{8'd9, 8'd5, 8'd1, 8'd4};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w3_rd%0d_data", i), rd_data[i], exp4[i]);
      check($sformatf("w3_rd%0d_resp", i), rd_resp[i], OKAY);
    end

    // ---- WRAP read len 3 at 0x02 ----
    axi_read(32'h02, 8'd3, WRAP, 3'd0, -1, '0);
`ifdef AXI_ALU_WRAP_BURST_EN
    exp4 = '{8'd1, 8'd4, 8'd9, 8'd5};
    expr = OKAY;
`else
    exp4 = '{8'd0, 8'd0, 8'd0, 8'd0};
    expr = SLVERR;
`endif
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_rd%0d_data", i), rd_data[i], exp4[i]);
      check($sformatf("wrap_rd%0d_resp", i), rd_resp[i], expr);
      check($sformatf("wrap_rd%0d_last", i), rd_last[i], (i == 3));
    end

    // ---- FIXED write: both beats land on the start word ----
    wbuf[0] = 8'd11; wbuf[1] = 8'd22;
    axi_write(32'h60, 8'd1, FIXED, 3'd0, resp);
    check("fixed_bresp", resp, OKAY);
    read1("fixed", 32'h60, 8'd22, OKAY);

    // ---- wrong beat size: dropped with SLVERR ----
    wbuf[0] = 8'd33;
    axi_write(32'h61, 8'd0, INCR, 3'd1, resp);
    check("size_bresp", resp, SLVERR);
    read1("size", 32'h61, 8'd0, OKAY);

    // ---- reserved burst read ----
    axi_read(32'h10, 8'd0, RSVD, 3'd0, -1, '0);
    check("rsvd_data", rd_data[0], 0);
    check("rsvd_resp", rd_resp[0], SLVERR);

    // ---- out of range: DECERR both directions ----
    read1("oor_rd", 32'(MW), 8'd0, DECERR);
    wbuf[0] = 8'd44;
    axi_write(32'(MW), 8'd0, INCR, 3'd0, resp);
    check("oor_bresp", resp, DECERR);

    // ---- reset mid-write burst ----
    @(negedge clk);
    awaddr = 32'h70; awlen = 8'd3; awburst = INCR; awsize = 3'd0; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wdata = 8'd1; wvalid = 1'b1; wlast = 1'b0;
    repeat (2) @(negedge clk);
    wvalid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_bvalid", bvalid, 0);
    check("midrst_awready", awready, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_awready_back", awready, 1);
    check("midrst_no_bvalid", bvalid, 0);
    read1("midrst_mem", 32'h13, 8'd0, OKAY);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/axi_alu_mem.md
AXI_ALU_MEM -- requirements
Module: axi_alu_mem

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_WIDTH SHALL default to 8; it is the beat width and memory word width, one of 8, 16 or 32.
REQ-003 Parameter ADDR_WIDTH SHALL default to 32; it is the AXI address width.
REQ-004 Parameter MEM_WORDS SHALL default to 64; it is the memory depth in words, a multiple of 4.
REQ-005 clk  in  1  system clock, all logic on rising edge.
REQ-006 rstn  in  1  synchronous active-low reset.
REQ-007 awaddr  in  ADDR_WIDTH  write burst start byte address.
REQ-008 awvalid  in  1  write address valid.
REQ-009 awready  out  1  write address ready.
REQ-010 awlen  in  8  write beats minus 1.
REQ-011 awsize  in  3  write beat size, log2 bytes.
REQ-012 awburst  in  2  write burst type: 00 FIXED, 01 INCR, 10 WRAP.
REQ-013 wdata  in  DATA_WIDTH  write data.
REQ-014 wvalid  in  1  write data valid.
REQ-015 wready  out  1  write data ready.
REQ-016 wlast  in  1  final write beat.
REQ-017 bresp  out  2  write response: 00 OKAY, 10 SLVERR, 11 DECERR.
REQ-018 bvalid  out  1  write response valid.
REQ-019 bready  in  1  write response ready.
REQ-020 araddr  in  ADDR_WIDTH  read burst start byte address.
REQ-021 arvalid  in  1  read address valid.
REQ-022 arready  out  1  read address ready.
REQ-023 arlen  in  8  read beats minus 1.
REQ-024 arsize  in  3  read beat size, log2 bytes.
REQ-025 arburst  in  2  read burst type, coded as awburst.
REQ-026 rdata  out  DATA_WIDTH  read data.
REQ-027 rvalid  out  1  read data valid.
REQ-028 rresp  out  2  read response, coded as bresp.
REQ-029 rready  in  1  read data ready.
REQ-030 rlast  out  1  final read beat.

Function
REQ-031 The memory SHALL be word-addressed, with word index = byte address / (DATA_WIDTH/8); words are grouped in slots of 4: word0 op1, word1 op2, word2 opcode, word3 result.
REQ-032 The result SHALL be DATA_WIDTH bits, truncated, with opcodes 0 add, 1 sub mod 2^DATA_WIDTH, 2 mul low bits, 3 op1 << op2[4:0], 4 and, 5 or, 6 xor, 7 pass op1, and result 0 for any other opcode.
REQ-033 Word3 SHALL be rewritten from the slot contents on the clock edge after any accepted beat to word0..2 of that slot, so a read issued 2+ cycles after the last write handshake returns the new result.
REQ-034 The write FSM SHALL cycle W_IDLE -> W_DATA -> W_RESP -> W_IDLE: awready=1 only in W_IDLE; on the AW handshake it latches addr/len/size/burst; wready=1 only in W_DATA; each W handshake writes one beat; after beat awlen+1 it enters W_RESP; bvalid holds until bready, then returns to W_IDLE.
REQ-035 The read FSM SHALL be independent of the write FSM: R_IDLE (arready=1) -> R_DATA; the first rvalid comes 1 cycle after the AR handshake; rdata/rvalid hold while rready=0; rlast=1 on beat arlen+1; after that handshake it returns to R_IDLE.
REQ-036 Beat addresses SHALL advance per burst type: FIXED holds the start address; INCR adds 1 word per beat; WRAP wraps within an aligned (len+1)-word window, legal only for len 1, 3, 7 or 15.
REQ-037 Error responses SHALL be as follows: a beat outside MEM_WORDS is not written, reads as 0 and gives DECERR; a write to word3, awsize/arsize not equal to log2(DATA_WIDTH/8), reserved burst 11, an illegal WRAP length, or wlast disagreeing with the beat count gives SLVERR with the beat dropped; DECERR outranks SLVERR; bresp is the worst of all beats.
REQ-038 On a same-cycle write beat and read of the same word, the read SHALL return the old data.

Reset
REQ-039 While rstn=0 at a clock edge, both FSMs SHALL go to IDLE, memory SHALL clear to 0, and awready, wready, bvalid, arready, rvalid and rlast SHALL be 0, with bresp, rresp and rdata all 0.
REQ-040 awready and arready SHALL rise the first edge after rstn=1; reset mid-burst SHALL abandon the burst with no response.

Configuration
REQ-041 With macro AXI_ALU_WRAP_BURST_EN defined, WRAP bursts SHALL be supported; without it, any WRAP burst SHALL be treated as reserved: no memory access, SLVERR, and the full beat count still consumed or returned.

Verification
REQ-042 DATA_WIDTH=8: INCR write len 2 at 0x00 of {5,3,0} -> bresp OKAY; INCR read len 3 at 0x00 returns 5,3,0,8 with rlast on beat 4.
REQ-043 Slots at 0x10 {10,4,1} -> 6, 0x20 {15,16,2} -> 240, 0x30 {2,3,3} -> 16, 0x40 {20,7,0} -> 27, each read back via single-beat reads.
REQ-044 Write len 3 at 0x00 including word3 -> bresp SLVERR; words 0..2 updated, word3 holds the computed result.
REQ-045 WRAP read len 3 at 0x02 with the macro defined -> words 2,3,0,1 returned, OKAY; without the macro -> 4 beats of rdata 0 with SLVERR.
REQ-046 rready held low 3 cycles mid-burst -> rdata/rvalid stable; read at word MEM_WORDS -> rdata 0 with DECERR; rstn pulsed mid-write -> no bvalid, and awready is back 1 cycle after release.
